// File: rtl/rotreg_pkg.sv
// Shared types for the rotating-register command path.
// FSM states and push-button index map.
package rotreg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2
  } state_e;

  localparam int NKEYS    = 4;
  localparam int KEY_LOAD = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_AUTO = 2;
  localparam int KEY_DIR  = 3;

endpackage

// File: rtl/rotreg_cmd_sequencer_if.sv
// Button/switch inputs and register-control outputs
// of the command sequencer, bundled as one port.
interface rotreg_cmd_sequencer_if #(
  parameter int WIDTH = 4
);
  import rotreg_pkg::*;

  logic [NKEYS-1:0] key_n;
  logic [WIDTH-1:0] data_in;
  logic             ls_in;
  logic             step;
  logic             load_n;
  logic             rotate_right;
  logic             ls_right;
  logic [WIDTH-1:0] data_out;
  logic             auto_on;

  modport master (
    output key_n, data_in, ls_in,
    input  step, load_n, rotate_right,
    input  ls_right, data_out, auto_on
  );

  modport slave (
    input  key_n, data_in, ls_in,
    output step, load_n, rotate_right,
    output ls_right, data_out, auto_on
  );

endinterface

// File: rtl/key_debouncer.sv
// One push-button: 2-FF sync, level debounce,
// and a 1-cycle pulse on each accepted press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count how long the synced level has disagreed with the
  // debounced one; accept it once the count is reached.
  always_comb begin
    cnt_d   = '0;
    db_d    = db_q;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        db_d    = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Released level on reset so a held key yields one press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rotreg_cmd_sequencer.sv
// Command stage for the rotating shift register:
// pending flags, auto-rotate ticker and strobe FSM.
module rotreg_cmd_sequencer
  import rotreg_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  rotreg_cmd_sequencer_if.slave  bus
);

  localparam int TW = $clog2(TICK_CYCLES);

  logic [NKEYS-1:0] press;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .key_n(bus.key_n[i]),
      .press(press[i])
    );
  end

  state_e           state_q, state_d;
  logic             load_p_q, load_p_d;
  logic             step_p_q, step_p_d;
  logic             step_man_q, step_man_d;
  logic             dir_p_q, dir_p_d;
  logic             auto_on_q, auto_on_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             step_q, step_d;
  logic             load_n_q, load_n_d;
  logic             rot_q, rot_d;
  logic             ls_q, ls_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             tick, serve_step, dir_req;

  // Next-state for flags, ticker, direction and the strobe FSM.
  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    load_n_d   = 1'b1;
    data_d     = data_q;
    rot_d      = rot_q;
    dir_p_d    = dir_p_q;
    tick_cnt_d = tick_cnt_q;
    ls_d       = bus.ls_in;

    tick = auto_on_q &&
           (tick_cnt_q == TW'(TICK_CYCLES - 1));
    serve_step = (state_q == IDLE) &&
                 !load_p_q && step_p_q;

    auto_on_d = auto_on_q ^ press[KEY_AUTO];

    // Manual steps restart the period so the
    // next automatic step is a full tick away.
    if (press[KEY_AUTO]) begin
      tick_cnt_d = '0;
    end else if (serve_step && step_man_q) begin
      tick_cnt_d = '0;
    end else if (auto_on_q) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    load_p_d = (load_p_q & ~((state_q == IDLE)))
             | press[KEY_LOAD];
    step_p_d = (step_p_q & ~serve_step)
             | press[KEY_STEP] | tick;
    step_man_d = (step_man_q & ~serve_step)
               | press[KEY_STEP];

    unique case (state_q)
      IDLE: begin
        if (load_p_q) begin
          state_d  = LOAD;
          step_d   = 1'b1;
          load_n_d = 1'b0;
          data_d   = bus.data_in;
        end else if (step_p_q) begin
          state_d = STEP;
          step_d  = 1'b1;
        end
      end
      LOAD, STEP: state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Direction only flips going into a quiet idle cycle,
    // never while a strobe is being issued.
    dir_req = dir_p_q | press[KEY_DIR];
    if (dir_req) begin
      if ((state_d == IDLE) && !load_p_d && !step_p_d) begin
        rot_d   = ~rot_q;
        dir_p_d = 1'b0;
      end else begin
        dir_p_d = 1'b1;
      end
    end
  end

  // All state and outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      load_p_q   <= 1'b0;
      step_p_q   <= 1'b0;
      step_man_q <= 1'b0;
      dir_p_q    <= 1'b0;
      auto_on_q  <= 1'b0;
      tick_cnt_q <= '0;
      step_q     <= 1'b0;
      load_n_q   <= 1'b1;
      rot_q      <= 1'b0;
      ls_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      load_p_q   <= load_p_d;
      step_p_q   <= step_p_d;
      step_man_q <= step_man_d;
      dir_p_q    <= dir_p_d;
      auto_on_q  <= auto_on_d;
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
      load_n_q   <= load_n_d;
      rot_q      <= rot_d;
      ls_q       <= ls_d;
      data_q     <= data_d;
    end
  end

  assign bus.step         = step_q;
  assign bus.load_n       = load_n_q;
  assign bus.rotate_right = rot_q;
  assign bus.ls_right     = ls_q;
  assign bus.data_out     = data_q;
  assign bus.auto_on      = auto_on_q;

endmodule

// File: tb/tb_rotreg_cmd_sequencer.sv
// Directed bench for rotreg_cmd_sequencer
// with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
module tb_rotreg_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;

  int nvec = 0;
  int nerr = 0;
  int nstb = 0;
  int k;
  logic last_ld = 1'b1;

  rotreg_cmd_sequencer_if #(.WIDTH(4)) bus ();

  rotreg_cmd_sequencer #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.step === 1'b1) begin
      nstb++;
      last_ld = bus.load_n;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_step(input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.step !== 1'b1 && n < lim);
  endtask

  task automatic wait_auto(input logic lvl, output int n);
    n = 0;
    while (bus.auto_on !== lvl && n < 30) begin
      cyc();
      n++;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_step"},   32'(bus.step), 0);
    chk({tag, "_load_n"}, 32'(bus.load_n), 1);
    chk({tag, "_rot"},    32'(bus.rotate_right), 0);
    chk({tag, "_ls"},     32'(bus.ls_right), 0);
    chk({tag, "_data"},   32'(bus.data_out), 0);
    chk({tag, "_auto"},   32'(bus.auto_on), 0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.key_n   = 4'hF;
    bus.data_in = 4'h0;
    bus.ls_in   = 1'b0;

    // 1: reset and quiet idle
    repeat (3) cyc();
    chk_reset_outs("t1_rst");
    reset = 1'b0;
    nstb = 0;
    repeat (50) cyc();
    chk("t1_no_step", nstb, 0);
    chk_reset_outs("t1_idle");

    bus.ls_in = 1'b1;
    cyc();
    chk("ls_hi", 32'(bus.ls_right), 1);
    bus.ls_in = 1'b0;
    cyc();
    chk("ls_lo", 32'(bus.ls_right), 0);

    // 2: bouncing load key
    bus.data_in = 4'b1011;
    nstb = 0;
    for (int i = 0; i < 3; i++) begin
      bus.key_n[0] = 1'b0;
      cyc(); cyc();
      bus.key_n[0] = 1'b1;
      cyc(); cyc();
    end
    chk("t2_bounce_quiet", nstb, 0);
    bus.key_n[0] = 1'b0;
    wait_step(20, k);
    chk("t2_load_lat", k, 9);
    chk("t2_load_n", 32'(bus.load_n), 0);
    nstb = 0;
    repeat (20) cyc();
    chk("t2_one_strobe", nstb, 0);
    chk("t2_data", 32'(bus.data_out), 32'hB);
    bus.data_in  = 4'b0101;
    bus.key_n[0] = 1'b1;
    repeat (20) cyc();
    chk("t2_release", nstb, 0);
    chk("t2_data_hold", 32'(bus.data_out), 32'hB);

    // 3: auto-rotate on, 5 ticks, off
    bus.key_n[2] = 1'b0;
    wait_auto(1'b1, k);
    chk("t3_auto_lat", k, 8);
    wait_step(20, k);
    chk("t3_first_tick", k, 9);
    chk("t3_ld0", 32'(bus.load_n), 1);
    for (int p = 1; p < 5; p++) begin
      wait_step(20, k);
      chk("t3_period", k, 8);
      chk("t3_ld", 32'(bus.load_n), 1);
    end
    bus.key_n[2] = 1'b1;
    repeat (10) cyc();
    bus.key_n[2] = 1'b0;
    wait_auto(1'b0, k);
    chk("t3_auto_off", 32'(bus.auto_on), 0);
    bus.key_n[2] = 1'b1;
    repeat (3) cyc();
    nstb = 0;
    repeat (30) cyc();
    chk("t3_no_more", nstb, 0);

    // 4: load press on the same cycle as a tick
    bus.data_in  = 4'b0110;
    bus.key_n[2] = 1'b0;
    repeat (8) cyc();
    bus.key_n[0] = 1'b0;
    nstb = 0;
    wait_step(20, k);
    chk("t4_lat", k, 9);
    chk("t4_load", 32'(bus.load_n), 0);
    chk("t4_data", 32'(bus.data_out), 32'h6);
    chk("t4_auto", 32'(bus.auto_on), 1);
    cyc();
    chk("t4_gap", 32'(bus.step), 0);
    cyc();
    chk("t4_step", 32'(bus.step), 1);
    chk("t4_step_ld", 32'(bus.load_n), 1);
    repeat (5) cyc();
    chk("t4_two", nstb, 2);
    bus.key_n = 4'hF;
    repeat (10) cyc();
    bus.key_n[2] = 1'b0;
    wait_auto(1'b0, k);
    chk("t4_auto_off", 32'(bus.auto_on), 0);
    bus.key_n = 4'hF;
    repeat (12) cyc();

    // 5: direction press during a STEP strobe
    chk("t5_rot_pre", 32'(bus.rotate_right), 0);
    bus.key_n[1] = 1'b0;
    cyc(); cyc();
    bus.key_n[3] = 1'b0;
    wait_step(20, k);
    chk("t5_lat", k, 7);
    chk("t5_ld", 32'(bus.load_n), 1);
    chk("t5_rot_strobe", 32'(bus.rotate_right), 0);
    cyc();
    chk("t5_idle", 32'(bus.step), 0);
    chk("t5_rot_flip", 32'(bus.rotate_right), 1);
    bus.key_n = 4'hF;
    repeat (12) cyc();
    chk("t5_rot_hold", 32'(bus.rotate_right), 1);

    // 6: reset mid-debounce with auto on
    bus.key_n[2] = 1'b0;
    wait_auto(1'b1, k);
    bus.key_n = 4'hF;
    repeat (10) cyc();
    bus.key_n[0] = 1'b0;
    repeat (3) cyc();
    chk("t6_auto_pre", 32'(bus.auto_on), 1);
    reset     = 1'b1;
    bus.key_n = 4'hF;
    cyc();
    reset = 1'b0;
    chk_reset_outs("t6_rst");
    nstb = 0;
    repeat (30) cyc();
    chk("t6_no_strobe", nstb, 0);
    chk("t6_auto", 32'(bus.auto_on), 0);

    // 7: load key held through reset
    bus.data_in  = 4'b1001;
    bus.key_n[0] = 1'b0;
    reset        = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    nstb  = 0;
    repeat (30) cyc();
    chk("t7_one", nstb, 1);
    chk("t7_ld", 32'(last_ld), 0);
    chk("t7_data", 32'(bus.data_out), 32'h9);
    bus.key_n = 4'hF;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
